// File: rtl/output_port_packetizer.sv
// Transmit end of a BFT leaf link: stamps user payload words with destination and a
// sequential receiver address, and meters them out against the receiver's buffer credits.
module output_port_packetizer #(
    parameter int PACKET_BITS           = 97,
    parameter int NUM_LEAF_BITS         = 6,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PAYLOAD_BITS          = 64,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                     clk_user,
    input  logic                     reset,
    input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
    input  logic [NUM_PORT_BITS-1:0] dst_port,
    input  logic [PAYLOAD_BITS-1:0]  din_user,
    input  logic                     vld_user,
    output logic                     ack2user,
    input  logic                     freespace_update,
    output logic [PACKET_BITS-1:0]   packet_out,
    input  logic                     ready_in,
    output logic [NUM_ADDR_BITS:0]   credit_cnt,
    output logic                     credit_err
);

    localparam int CW      = NUM_ADDR_BITS + 1;
    localparam int PAD     = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS - NUM_ADDR_BITS - PAYLOAD_BITS;
    localparam int SUM_W   = CW + 1;

    localparam logic [CW-1:0]          DEPTH_C  = CW'(2**NUM_ADDR_BITS);
    localparam logic [SUM_W-1:0]       DEPTH_S  = SUM_W'(2**NUM_ADDR_BITS);
    localparam logic [SUM_W-1:0]       UPD_INC  = SUM_W'(FREESPACE_UPDATE_SIZE);
    localparam logic [SUM_W-1:0]       SUM_ONE  = SUM_W'(1);
    localparam logic [NUM_ADDR_BITS-1:0] ADDR_ONE = NUM_ADDR_BITS'(1);

    logic [PACKET_BITS-1:0]   r_packet;
    logic [NUM_ADDR_BITS-1:0] r_addr;
    logic [CW-1:0]            r_credit;
    logic                     r_err;

    logic                     w_slot_free;
    logic                     w_ack;
    logic [SUM_W-1:0]         w_credit_sum;

    // The output slot can be refilled in the same cycle the downstream takes it.
    assign w_slot_free = ~r_packet[PACKET_BITS-1] | ready_in;
    assign w_ack       = vld_user & (r_credit != '0) & w_slot_free & ~reset;

    always_comb begin
        w_credit_sum = {1'b0, r_credit};
        if (freespace_update) w_credit_sum = w_credit_sum + UPD_INC;
        if (w_ack)            w_credit_sum = w_credit_sum - SUM_ONE;
    end

    always_ff @(posedge clk_user) begin
        if (reset) begin
            r_packet <= '0;
            r_addr   <= '0;
            r_credit <= DEPTH_C;
            r_err    <= 1'b0;
        end else begin
            if (w_ack) begin
                r_packet <= {1'b1, dst_leaf, dst_port, {PAD{1'b0}}, r_addr, din_user};
                r_addr   <= r_addr + ADDR_ONE;
            end else if (ready_in) begin
                r_packet[PACKET_BITS-1] <= 1'b0;
            end

            // More credit than buffer slots means the receiver over-reported; clamp and flag.
            if (w_credit_sum > DEPTH_S) begin
                r_credit <= DEPTH_C;
                r_err    <= 1'b1;
            end else begin
                r_credit <= w_credit_sum[CW-1:0];
            end
        end
    end

    assign ack2user   = w_ack;
    assign packet_out = r_packet;
    assign credit_cnt = r_credit;
    assign credit_err = r_err;

endmodule
